// File: rtl/rallyx_pkg.sv
// Shared definitions for the Rally-X wall sensor: world geometry, heading
// encodings and the scan FSM state type.
package rallyx_pkg;

    localparam int WORLD_W     = 1280;
    localparam int WORLD_H     = 960;
    localparam int TILE_SHIFT  = 4;
    localparam int MAP_TILES_X = 80;
    localparam int LEVEL_TILES = 4800;

    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        PROBE = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/wall_probe_addr.sv
// Maps the latched car position/heading and a probe index to a tile-map ROM
// address plus an in-bounds flag. Purely combinational.
module wall_probe_addr
    import rallyx_pkg::*;
#(
    parameter int LOOKAHEAD = 2
) (
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic [10:0] half_s,
    input  logic [3:0]  heading,
    input  logic [1:0]  probe_idx,
    input  logic [1:0]  level,
    output logic        in_bounds,
    output logic [14:0] addr
);

    localparam logic signed [12:0] LA    = 13'(LOOKAHEAD);
    localparam logic signed [12:0] X_MAX = 13'(WORLD_W - 1);
    localparam logic signed [12:0] Y_MAX = 13'(WORLD_H - 1);

    logic signed [12:0] sx, sy, ss, reach, offset, px, py;
    logic               heading_ok;
    logic [12:0]        col, row;

    assign sx    = signed'({2'b00, pos_x});
    assign sy    = signed'({2'b00, pos_y});
    assign ss    = signed'({2'b00, half_s});
    assign reach = ss + LA;

    // Offset along the leading edge: low corner, centre, high corner.
    always_comb begin
        case (probe_idx)
            2'd0:    offset = 13'sd1 - ss;
            2'd1:    offset = '0;
            default: offset = ss - 13'sd1;
        endcase
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        px         = sx;
        py         = sy;
        heading_ok = 1'b1;
        case (heading)
            DIR_UP:    begin py = sy - reach; px = sx + offset; end
            DIR_DOWN:  begin py = sy + reach; px = sx + offset; end
            DIR_RIGHT: begin px = sx + reach; py = sy + offset; end
            DIR_LEFT:  begin px = sx - reach; py = sy + offset; end
            default:   heading_ok = 1'b0;
        endcase
    end

    assign in_bounds = heading_ok && (px >= 0) && (py >= 0) &&
                       (px <= X_MAX) && (py <= Y_MAX);

    // Coordinates are non-negative whenever the address is actually used.
    assign col  = unsigned'(px) >> TILE_SHIFT;
    assign row  = unsigned'(py) >> TILE_SHIFT;
    assign addr = ({13'd0, level} * 15'(LEVEL_TILES)) +
                  (15'(row) * 15'(MAP_TILES_X)) + 15'(col);

endmodule

// File: rtl/wall_sensor.sv
// Once-per-frame wall sensor: latches the car state, reads the tile map at
// three probes ahead of the leading edge and reports the first wall code.
module wall_sensor
    import rallyx_pkg::*;
#(
    parameter int LOOKAHEAD = 2,
    parameter int ROM_LAT   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [1:0]  levelindex,
    input  logic [10:0] BallX,
    input  logic [10:0] BallY,
    input  logic [10:0] BallS,
    input  logic [3:0]  playerVelocity,
    output logic [14:0] rom_addr,
    output logic        rom_rd,
    input  logic [4:0]  rom_data,
    output logic [4:0]  map_on,
    output logic        scan_done,
    output logic        overrun
);

    localparam int                CNT_W    = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ROM_LAT);

    scan_state_t state, state_next;

    logic [10:0]      lat_x, lat_y, lat_s;
    logic [3:0]       lat_vel;
    logic [1:0]       lat_lvl;
    logic [1:0]       probe;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       result, result_next;
    logic             in_bounds, slot_first, slot_last, scan_last;
    logic [14:0]      probe_addr;

    wall_probe_addr #(.LOOKAHEAD(LOOKAHEAD)) u_probe (
        .pos_x     (lat_x),
        .pos_y     (lat_y),
        .half_s    (lat_s),
        .heading   (lat_vel),
        .probe_idx (probe),
        .level     (lat_lvl),
        .in_bounds (in_bounds),
        .addr      (probe_addr)
    );

    assign slot_first = (state == PROBE) && (cnt == '0);
    assign slot_last  = (state == PROBE) && (cnt == CNT_LAST);
    assign scan_last  = slot_last && (probe == 2'd2);

    // Skipped probes still run a full slot but contribute nothing.
    assign result_next = (result != '0) ? result : (in_bounds ? rom_data : 5'd0);

    assign rom_rd    = slot_first && in_bounds;
    assign rom_addr  = slot_first ? probe_addr : 15'd0;
    assign scan_done = (state == DONE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick) state_next = LATCH;
            LATCH:   state_next = PROBE;
            PROBE:   if (scan_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            lat_x   <= '0;
            lat_y   <= '0;
            lat_s   <= '0;
            lat_vel <= '0;
            lat_lvl <= '0;
            probe   <= '0;
            cnt     <= '0;
            result  <= '0;
            map_on  <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_next;
            if (frame_tick && state != IDLE)
                overrun <= 1'b1;

            case (state)
                LATCH: begin
                    lat_x   <= BallX;
                    lat_y   <= BallY;
                    lat_s   <= BallS;
                    lat_vel <= playerVelocity;
                    lat_lvl <= levelindex;
                    probe   <= '0;
                    cnt     <= '0;
                    result  <= '0;
                end
                PROBE: begin
                    if (slot_last) begin
                        cnt    <= '0;
                        probe  <= probe + 2'd1;
                        result <= result_next;
                        if (probe == 2'd2)
                            map_on <= result_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wall_sensor.sv
// Directed bench for wall_sensor with a pipelined tile-map ROM model.
module tb_wall_sensor;

    localparam int ROM_LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_tick;
    logic [1:0]  levelindex;
    logic [10:0] BallX, BallY, BallS;
    logic [3:0]  playerVelocity;
    logic [14:0] rom_addr;
    logic        rom_rd;
    logic [4:0]  rom_data;
    logic [4:0]  map_on;
    logic        scan_done;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    wall_sensor #(.LOOKAHEAD(2), .ROM_LAT(ROM_LAT)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .frame_tick     (frame_tick),
        .levelindex     (levelindex),
        .BallX          (BallX),
        .BallY          (BallY),
        .BallS          (BallS),
        .playerVelocity (playerVelocity),
        .rom_addr       (rom_addr),
        .rom_rd         (rom_rd),
        .rom_data       (rom_data),
        .map_on         (map_on),
        .scan_done      (scan_done),
        .overrun        (overrun)
    );

    always #5 Clk = ~Clk;

    // ROM model: address registered, data valid ROM_LAT cycles later.
    logic [4:0] rom [0:32767];
    logic [4:0] rom_pipe [0:ROM_LAT-1];

    always @(posedge Clk) begin
        rom_pipe[0] <= rom[rom_addr];
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Starts a scan at the current negedge (cycle 0) and follows it cycle by
    // cycle. tick2_at / rst_at inject a second frame_tick or a Reset.
    task automatic scan(input string tag,
                        input logic [10:0] x, input logic [10:0] y, input logic [10:0] s,
                        input logic [3:0] vel, input logic [1:0] lvl,
                        input int tick2_at, input int rst_at,
                        input logic [4:0] exp_map, input int exp_n,
                        input logic [14:0] e0, input logic [14:0] e1, input logic [14:0] e2);
        logic [14:0] got [3];
        logic [14:0] expa [3];
        int nrd;
        bit done;
        bit aborted;
        nrd = 0; done = 0; aborted = 0;
        expa[0] = e0; expa[1] = e1; expa[2] = e2;
        BallX = x; BallY = y; BallS = s; playerVelocity = vel; levelindex = lvl;
        frame_tick = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge Clk);
            if (rst_at != 0 && k == rst_at + 1) begin
                check({tag, " rst map_on"},    32'(map_on),    32'd0);
                check({tag, " rst scan_done"}, 32'(scan_done), 32'd0);
                check({tag, " rst overrun"},   32'(overrun),   32'd0);
                check({tag, " rst rom_rd"},    32'(rom_rd),    32'd0);
                check({tag, " rst rom_addr"},  32'(rom_addr),  32'd0);
                Reset = 1'b0;
                aborted = 1;
                break;
            end
            if (rom_rd) begin
                if (nrd < 3) got[nrd] = rom_addr;
                nrd++;
            end
            if (scan_done) begin
                check({tag, " done cycle"}, 32'(k), 32'd11);
                check({tag, " map_on"}, 32'(map_on), 32'(exp_map));
                done = 1;
                break;
            end
            frame_tick = (k == tick2_at);
            Reset      = (rst_at != 0 && k == rst_at);
            if (k >= 2) begin
                BallX = 11'h7FF; BallY = 11'h000; BallS = 11'h3FF;
                playerVelocity = 4'b1000; levelindex = 2'd3;
            end
        end
        frame_tick = 1'b0;
        if (!aborted) begin
            if (!done) check({tag, " timeout"}, 32'd0, 32'd1);
            check({tag, " read count"}, 32'(nrd), 32'(exp_n));
            for (int i = 0; i < 3; i++)
                if (i < exp_n && i < nrd)
                    check($sformatf("%s read%0d addr", tag, i), 32'(got[i]), 32'(expa[i]));
            @(negedge Clk);
            check({tag, " done pulse"}, 32'(scan_done), 32'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) rom[i] = 5'd0;
        rom[0]    = 5'h1F;
        rom[2280] = 5'h03;
        rom[2361] = 5'h01;
        rom[2521] = 5'h07;
        rom[2520] = 5'h0A;

        Reset = 1'b1; frame_tick = 1'b0; levelindex = 2'd0;
        BallX = '0; BallY = '0; BallS = '0; playerVelocity = '0;
        repeat (3) @(negedge Clk);
        check("reset map_on",    32'(map_on),    32'd0);
        check("reset scan_done", 32'(scan_done), 32'd0);
        check("reset overrun",   32'(overrun),   32'd0);
        check("reset rom_rd",    32'(rom_rd),    32'd0);
        check("reset rom_addr",  32'(rom_addr),  32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        scan("up", 11'd640, 11'd480, 11'd16, 4'b0001, 2'd0, 0, 0, 5'h03, 3, 15'd2279, 15'd2280, 15'd2280);
        repeat (4) @(negedge Clk);
        check("map_on holds", 32'(map_on), 32'h03);

        scan("edge", 11'd10, 11'd480, 11'd16, 4'b1000, 2'd0, 0, 0, 5'h00, 0, 15'd0, 15'd0, 15'd0);
        scan("level1", 11'd640, 11'd480, 11'd16, 4'b0001, 2'd1, 0, 0, 5'h00, 3, 15'd7079, 15'd7080, 15'd7080);
        scan("prio", 11'd640, 11'd488, 11'd16, 4'b0100, 2'd0, 0, 0, 5'h01, 3, 15'd2361, 15'd2441, 15'd2521);
        scan("down", 11'd640, 11'd480, 11'd16, 4'b0010, 2'd0, 0, 0, 5'h0A, 3, 15'd2519, 15'd2520, 15'd2520);
        scan("invalid", 11'd640, 11'd480, 11'd16, 4'b0011, 2'd0, 0, 0, 5'h00, 0, 15'd0, 15'd0, 15'd0);
        check("overrun clear", 32'(overrun), 32'd0);

        scan("ovr", 11'd640, 11'd480, 11'd16, 4'b0001, 2'd0, 4, 0, 5'h03, 3, 15'd2279, 15'd2280, 15'd2280);
        check("overrun set", 32'(overrun), 32'd1);
        repeat (3) @(negedge Clk);
        check("overrun sticky", 32'(overrun), 32'd1);

        scan("rst", 11'd640, 11'd488, 11'd16, 4'b0100, 2'd0, 0, 5, 5'h00, 0, 15'd0, 15'd0, 15'd0);
        @(negedge Clk);
        scan("after rst", 11'd640, 11'd488, 11'd16, 4'b0100, 2'd0, 0, 0, 5'h01, 3, 15'd2361, 15'd2441, 15'd2521);
        check("overrun after rst", 32'(overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
